logic_unit_seq: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 33 +++
 rtl/logic_unit_seq_fold.sv | 72 +++++++
 rtl/logic_unit_seq.sv | 149 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Shared types and helpers for the registered logic unit:
//                operation codes, controller states, reduction classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_RNOR = 3'b110,
        OP_RXOR = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RED  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Reduction ops are the only multi-cycle operations.
    function automatic logic is_reduction(input op_t op);
        return (op == OP_RNOR) || (op == OP_RXOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_seq_fold.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_fold
//  Description : LANES-wide reduction fold stage. Loads the operand into a
//                zero-padded shift register, folds LANES bits per cycle into
//                a one-bit accumulator (OR or XOR) and flags the last fold.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_fold
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             enable,
    input  op_t              op,
    input  logic [WIDTH-1:0] data,
    output logic             done,
    output logic             result
);

    localparam int c_n_folds = (WIDTH + LANES - 1) / LANES;
    localparam int c_pad_w   = c_n_folds * LANES;
    localparam int c_cnt_w   = $clog2(c_n_folds + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_end  = c_cnt_w'(c_n_folds);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n_folds - 1);

    logic [c_pad_w-1:0] r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_acc;
    logic               r_is_xor;

    logic [LANES-1:0]   w_chunk;
    logic               w_fold_bit;
    logic               w_acc_nxt;
    logic               w_active;

    assign w_chunk    = r_shift[LANES-1:0];
    assign w_fold_bit = r_is_xor ? (^w_chunk) : (|w_chunk);
    assign w_acc_nxt  = r_is_xor ? (r_acc ^ w_fold_bit) : (r_acc | w_fold_bit);
    assign w_active   = enable && (r_cnt != c_cnt_end);

    // The last fold is combined combinationally so the result can be written
    // on the same edge that performs it.
    assign done   = w_active && (r_cnt == c_cnt_last);
    assign result = (done ? w_acc_nxt : r_acc) ^ ~r_is_xor;

    // Shift register, accumulator and saturating fold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_acc    <= 1'b0;
            r_is_xor <= 1'b0;
        end else if (start) begin
            r_shift  <= c_pad_w'(data);
            r_cnt    <= '0;
            r_acc    <= 1'b0;
            r_is_xor <= (op == OP_RXOR);
        end else if (w_active) begin
            r_shift  <= r_shift >> LANES;
            r_cnt    <= r_cnt + 1'b1;
            r_acc    <= w_acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_seq
//  Description : Registered multi-function logic unit with valid/ready on
//                both sides. Bitwise ops complete in one cycle; reduction
//                ops (RNOR/RXOR) fold LANES bits per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_z;

    op_t              w_op;
    logic             w_out_free;
    logic             w_accept;
    logic             w_drain;
    logic             w_red_start;
    logic [WIDTH-1:0] w_bitwise;
    logic [WIDTH-1:0] w_red_word;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_fold_done;
    logic             w_fold_bit;

    assign w_op        = op_t'(op);
    assign w_out_free  = !r_out_valid || out_ready;
    assign in_ready    = (r_state == ST_IDLE) && w_out_free;
    assign w_accept    = in_valid && in_ready;
    assign w_drain     = r_out_valid && out_ready;
    assign w_red_start = w_accept && is_reduction(w_op);

    assign out_valid = r_out_valid;
    assign z         = r_z;

    // Single-cycle bitwise datapath.
    always_comb begin
        w_bitwise = '0;
        case (w_op)
            OP_AND:  w_bitwise = a & b;
            OP_OR:   w_bitwise = a | b;
            OP_NOR:  w_bitwise = ~(a | b);
            OP_NAND: w_bitwise = ~(a & b);
            OP_XOR:  w_bitwise = a ^ b;
            OP_XNOR: w_bitwise = ~(a ^ b);
            default: w_bitwise = '0;
        endcase
    end

    // Reduction results occupy bit 0 only.
    always_comb begin
        w_red_word    = '0;
        w_red_word[0] = w_fold_bit;
    end

    logic_unit_fold #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_fold (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_red_start),
        .enable (r_state == ST_RED),
        .op     (w_op),
        .data   (a),
        .done   (w_fold_done),
        .result (w_fold_bit)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and result-register write decode.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_data   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_reduction(w_op)) begin
                        w_state_nxt = ST_RED;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_bitwise;
                    end
                end
            end
            ST_RED: begin
                if (w_fold_done) begin
                    if (w_out_free) begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = w_red_word;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_out_free) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = w_red_word;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result register: a write wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_z         <= '0;
        end else if (w_wr_en) begin
            r_out_valid <= 1'b1;
            r_z         <= w_wr_data;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_seq
//  Description : Directed self-checking bench for logic_unit_seq, covering
//                the default 8/2 configuration and a ragged 7/2 one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_ready;

    logic       in_ready8;
    logic       out_valid8;
    logic [7:0] z8;
    logic       in_ready7;
    logic       out_valid7;
    logic [6:0] z7;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(8), .LANES(2)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .z         (z8)
    );

    logic_unit_seq #(.WIDTH(7), .LANES(2)) u_dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready7),
        .op        (op),
        .a         (a[6:0]),
        .b         (b[6:0]),
        .out_valid (out_valid7),
        .out_ready (out_ready),
        .z         (z7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a reduction to both instances and check busy/latency/result.
    task automatic run_red(input string tag, input logic [2:0] r_op, input logic [7:0] r_a,
                           input logic [7:0] exp8, input logic [6:0] exp7);
        in_valid = 1'b1;
        op       = r_op;
        a        = r_a;
        b        = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy_rdy"}, {31'd0, in_ready8}, 32'd0);
            check({tag, "_busy_vld"}, {31'd0, out_valid8}, 32'd0);
            tick();
        end
        check({tag, "_vld8"}, {31'd0, out_valid8}, 32'd1);
        check({tag, "_z8"}, {24'd0, z8}, {24'd0, exp8});
        check({tag, "_vld7"}, {31'd0, out_valid7}, 32'd1);
        check({tag, "_z7"}, {25'd0, z7}, {25'd0, exp7});
        tick();
        check({tag, "_drained"}, {31'd0, out_valid8}, 32'd0);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_vld", {31'd0, out_valid8}, 32'd0);
        check("rst_z", {24'd0, z8}, 32'd0);
        check("rst_rdy", {31'd0, in_ready8}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-reduction.
        in_valid = 1'b1;
        op       = 3'b110;
        a        = 8'h00;
        tick();
        in_valid = 1'b0;
        check("midrst_busy", {31'd0, in_ready8}, 32'd0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_vld", {31'd0, out_valid8}, 32'd0);
        check("midrst_z", {24'd0, z8}, 32'd0);
        check("midrst_rdy", {31'd0, in_ready8}, 32'd1);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid8 || out_valid7) seen = 1'b1;
        end
        check("midrst_noresult", {31'd0, seen}, 32'd0);

        // Back-to-back bitwise ops.
        in_valid = 1'b1;
        op       = 3'b010;
        a        = 8'hF0;
        b        = 8'h0C;
        check("nor_rdy", {31'd0, in_ready8}, 32'd1);
        tick();
        check("nor_vld", {31'd0, out_valid8}, 32'd1);
        check("nor_z", {24'd0, z8}, 32'h03);
        op = 3'b100;
        a  = 8'hFF;
        b  = 8'h0F;
        check("xor_rdy", {31'd0, in_ready8}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("xor_vld", {31'd0, out_valid8}, 32'd1);
        check("xor_z", {24'd0, z8}, 32'hF0);
        tick();
        check("xor_drained", {31'd0, out_valid8}, 32'd0);

        // Reductions, both widths in parallel.
        run_red("rnor00", 3'b110, 8'h00, 8'h01, 7'h01);
        run_red("rnor10", 3'b110, 8'h10, 8'h00, 7'h00);
        run_red("rxorB5", 3'b111, 8'hB5, 8'h01, 7'h00);
        run_red("rxor81", 3'b111, 8'h81, 8'h00, 7'h01);
        run_red("rnor40", 3'b110, 8'h40, 8'h00, 7'h00);
        run_red("rxor7F", 3'b111, 8'h7F, 8'h01, 7'h01);

        // Backpressure on the result register.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b000;
        a         = 8'h0F;
        b         = 8'hFC;
        tick();
        op = 3'b001;
        a  = 8'h30;
        b  = 8'h03;
        check("bp_rdy", {31'd0, in_ready8}, 32'd0);
        check("bp_vld", {31'd0, out_valid8}, 32'd1);
        check("bp_z", {24'd0, z8}, 32'h0C);
        tick();
        check("bp_hold_rdy", {31'd0, in_ready8}, 32'd0);
        check("bp_hold_z", {24'd0, z8}, 32'h0C);
        check("bp_hold_vld", {31'd0, out_valid8}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'd0, in_ready8}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_or_vld", {31'd0, out_valid8}, 32'd1);
        check("bp_or_z", {24'd0, z8}, 32'h33);
        tick();
        check("bp_drained", {31'd0, out_valid8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
